// File: rtl/cpu_ctrl_pkg.sv
// Shared types and opcode constants for the CPU sequencer and its decoder.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_STORE = 6'b010000;
    localparam logic [5:0] OP_LOAD  = 6'b010001;
    localparam logic [5:0] OP_BR    = 6'b100000;
    localparam logic [5:0] OP_JMP   = 6'b100001;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_ERR
    } seq_state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_HALT,
        CL_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier used by the decode phase.
module op_classify
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_class_t  op_class
);

    // Map the 6-bit opcode onto its instruction class.
    always_comb begin
        op_class = CL_ILLEGAL;
        if (op[5:4] == 2'b00) begin
            op_class = CL_ALU;
        end else begin
            case (op)
                OP_STORE: op_class = CL_STORE;
                OP_LOAD:  op_class = CL_LOAD;
                OP_BR:    op_class = CL_BRANCH;
                OP_JMP:   op_class = CL_JUMP;
                OP_HALT:  op_class = CL_HALT;
                default:  op_class = CL_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: memory handshakes, stage enables,
// PC ownership and retire counting for the single-issue CPU.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned PC_STEP     = 4,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        reg_update,
    input  logic        pc_update,
    input  logic [31:0] pc_new,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_en,
    output logic        id_en,
    output logic        ex_en,
    output logic        wb_en,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic        busy,
    output logic        halted,
    output logic        bus_err,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    localparam logic [31:0] PC_INC       = 32'(PC_STEP);
    localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT - 1);

    seq_state_t  state;
    seq_state_t  state_d;
    op_class_t   dec_class;
    op_class_t   cls_q;
    logic [31:0] wait_cnt;
    logic [31:0] pc_next;
    logic        timeout_hit;
    logic        retire;
    logic        is_mem_op;

    op_classify u_op_classify (
        .op       (op),
        .op_class (dec_class)
    );

    // The IR must capture the word in the very cycle it is valid, and the
    // register-file strobe follows the write stage's request in WB.
    assign ir_en = imem_req & imem_ready;
    assign rf_we = wb_en & reg_update;

    // A wait state gives up once MEM_TIMEOUT cycles have passed without
    // ready; ready on that last cycle still wins.
    assign timeout_hit = (wait_cnt == TIMEOUT_LAST);
    assign is_mem_op   = (cls_q == CL_LOAD) || (cls_q == CL_STORE);

    // Next-state selection and retire/PC commit decision.
    always_comb begin
        state_d = state;
        retire  = 1'b0;
        pc_next = pc + PC_INC;
        case (state)
            ST_IDLE: begin
                if (start) state_d = ST_IF;
            end
            ST_IF: begin
                if (imem_ready)       state_d = ST_ID;
                else if (timeout_hit) state_d = ST_ERR;
            end
            ST_ID: begin
                case (dec_class)
                    CL_HALT:    state_d = ST_HALT;
                    CL_ILLEGAL: begin
                        state_d = ST_IF;
                        retire  = 1'b1;
                    end
                    default:    state_d = ST_EX;
                endcase
            end
            ST_EX: begin
                state_d = is_mem_op ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (cls_q == CL_STORE) begin
                        state_d = ST_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                state_d = ST_IF;
                retire  = 1'b1;
                if (pc_update) pc_next = pc_new;
            end
            default: state_d = state;
        endcase
    end

    // Sequencer state, registered strobes, PC and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cls_q     <= CL_ALU;
            pc        <= PC_RESET;
            instr_cnt <= '0;
            wait_cnt  <= '0;
            imem_req  <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            id_en     <= 1'b0;
            ex_en     <= 1'b0;
            wb_en     <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            bus_err   <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state    <= state_d;
            imem_req <= (state_d == ST_IF);
            dmem_req <= (state_d == ST_MEM);
            dmem_we  <= (state_d == ST_MEM) && (cls_q == CL_STORE);
            id_en    <= (state_d == ST_ID);
            ex_en    <= (state_d == ST_EX);
            wb_en    <= (state_d == ST_WB);
            busy     <= !((state_d == ST_IDLE) || (state_d == ST_HALT));
            halted   <= (state_d == ST_HALT);
            if (state_d == ST_ERR) bus_err <= 1'b1;
            if (state == ST_ID) cls_q <= dec_class;
            if ((state == ST_ID) && (dec_class == CL_ILLEGAL)) illegal <= 1'b1;
            if (retire) begin
                pc        <= pc_next;
                instr_cnt <= instr_cnt + 32'd1;
            end
            if (((state == ST_IF) || (state == ST_MEM)) && (state_d == state))
                wait_cnt <= wait_cnt + 32'd1;
            else
                wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Self-checking bench for cpu_seq_ctrl: directed scenarios plus random
// instruction streams against a phase-level model of the sequencer.
module tb_cpu_seq_ctrl;

    localparam int unsigned TO = 4;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JMP = 4, K_HALT = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        rst, start, imem_ready, dmem_ready, reg_update, pc_update;
    logic [5:0]  op;
    logic [31:0] pc_new;
    logic        imem_req, dmem_req, dmem_we, ir_en, id_en, ex_en, wb_en, rf_we;
    logic        busy, halted, bus_err, illegal;
    logic [31:0] pc, instr_cnt;

    cpu_seq_ctrl #(
        .PC_RESET    (32'h0000_0000),
        .PC_STEP     (4),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .reg_update(reg_update), .pc_update(pc_update), .pc_new(pc_new),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_en(ir_en), .id_en(id_en), .ex_en(ex_en), .wb_en(wb_en),
        .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted),
        .bus_err(bus_err), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_pc, m_cnt;
    logic        m_halted, m_err, m_ill;
    logic        e_imem, e_dmem, e_we, e_ir, e_id, e_ex, e_wb, e_rf, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(e_imem));
        chk("dmem_req", 32'(dmem_req), 32'(e_dmem));
        chk("dmem_we", 32'(dmem_we), 32'(e_we));
        chk("ir_en", 32'(ir_en), 32'(e_ir));
        chk("id_en", 32'(id_en), 32'(e_id));
        chk("ex_en", 32'(ex_en), 32'(e_ex));
        chk("wb_en", 32'(wb_en), 32'(e_wb));
        chk("rf_we", 32'(rf_we), 32'(e_rf));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("bus_err", 32'(bus_err), 32'(m_err));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("pc", pc, m_pc);
        chk("instr_cnt", instr_cnt, m_cnt);
    endtask

    // One clock: compare mid-cycle, then advance to just after the next edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic im, dm, we, ir, id, ex, wb, rf, bz);
        e_imem = im; e_dmem = dm; e_we = we; e_ir = ir; e_id = id;
        e_ex = ex; e_wb = wb; e_rf = rf; e_busy = bz;
    endtask

    // Inputs that must not matter in the current phase get random values.
    task automatic rand_side();
        start      = 1'($urandom);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        reg_update = 1'($urandom);
        pc_update  = 1'($urandom);
        pc_new     = $urandom & 32'hFFFF_FFFC;
    endtask

    function automatic int op_kind(input logic [5:0] o);
        if (o[5:4] == 2'b00) return K_ALU;
        case (o)
            6'b010000: return K_ST;
            6'b010001: return K_LD;
            6'b100000: return K_BR;
            6'b100001: return K_JMP;
            6'b111111: return K_HALT;
            default:   return K_ILL;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_cnt = 32'h0;
        m_halted = 1'b0; m_err = 1'b0; m_ill = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rand_side();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
    endtask

    task automatic begin_run();
        rand_side();
        start = 1'b1;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // Terminal states: nothing requested, start has no effect.
    task automatic hold_terminal();
        for (int i = 0; i < 3; i++) begin
            rand_side();
            start = 1'b1;
            set_exp(0, 0, 0, 0, 0, 0, 0, 0, m_err && !m_halted);
            tick();
        end
    endtask

    // Drives one instruction from its first fetch cycle through commit.
    // iw/dw: cycles of ready-low before ready (>= TO means ready never comes).
    task automatic run_instr(input logic [5:0] op_i, input int iw, input int dw,
                             input logic ru, input logic pu, input logic [31:0] pn,
                             input bit rst_mem, output bit stop);
        int  kind;
        bit  rdy;
        stop = 1'b0;
        kind = op_kind(op_i);
        for (int k = 0; k < int'(TO); k++) begin
            rand_side();
            op = op_i;
            rdy = (k == iw);
            imem_ready = rdy;
            set_exp(1, 0, 0, rdy, 0, 0, 0, 0, 1);
            tick();
            if (rdy) break;
        end
        if (iw >= int'(TO)) begin
            m_err = 1'b1; stop = 1'b1;
            return;
        end
        rand_side();
        set_exp(0, 0, 0, 0, 1, 0, 0, 0, 1);
        tick();
        if (kind == K_HALT) begin
            m_halted = 1'b1; stop = 1'b1;
            return;
        end
        if (kind == K_ILL) begin
            m_ill = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
            return;
        end
        rand_side();
        set_exp(0, 0, 0, 0, 0, 1, 0, 0, 1);
        tick();
        if (kind == K_LD || kind == K_ST) begin
            for (int k = 0; k < int'(TO); k++) begin
                rand_side();
                rdy = (k == dw) && !rst_mem;
                dmem_ready = rdy;
                set_exp(0, 1, kind == K_ST, 0, 0, 0, 0, 0, 1);
                if (rst_mem) rst = 1'b1;
                tick();
                if (rst_mem) begin
                    rst = 1'b0; model_reset(); stop = 1'b1;
                    return;
                end
                if (rdy) break;
            end
            if (dw >= int'(TO)) begin
                m_err = 1'b1; stop = 1'b1;
                return;
            end
            if (kind == K_ST) begin
                m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
                return;
            end
        end
        rand_side();
        reg_update = ru; pc_update = pu; pc_new = pn;
        set_exp(0, 0, 0, 0, 0, 0, 1, ru, 1);
        tick();
        m_pc  = pu ? pn : m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ill [5];
        int r;
        ill[0] = 6'b110000; ill[1] = 6'b010010; ill[2] = 6'b100010;
        ill[3] = 6'b111110; ill[4] = 6'b011111;
        r = $urandom_range(0, 39);
        if (r < 12)  return {2'b00, 4'($urandom)};
        if (r < 17)  return 6'b010001;
        if (r < 22)  return 6'b010000;
        if (r < 28)  return 6'b100000;
        if (r < 33)  return 6'b100001;
        if (r < 38)  return ill[$urandom_range(0, 4)];
        if (r == 38) return 6'b111111;
        return 6'b000000;
    endfunction

    initial begin
        bit stop;
        rst = 1'b0;
        op  = 6'd0;
        rand_side();
        model_reset();

        // Reset state and a plain ALU instruction with immediate readies.
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_cnt", instr_cnt, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        begin_run();
        run_instr(6'b000010, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0, stop);
        chk("alu_pc", pc, 32'h4);
        chk("alu_cnt", instr_cnt, 32'h1);

        // Branch taken then not taken.
        run_instr(6'b100000, 0, 0, 1'b0, 1'b1, 32'h40, 1'b0, stop);
        chk("br_taken_pc", pc, 32'h40);
        run_instr(6'b100000, 1, 0, 1'b0, 1'b0, 32'h80, 1'b0, stop);
        chk("br_fall_pc", pc, 32'h44);

        // Load with three wait cycles, then a store.
        run_instr(6'b010001, 0, 3, 1'b1, 1'b0, 32'h0, 1'b0, stop);
        run_instr(6'b010000, 0, 1, 1'b1, 1'b1, 32'h100, 1'b0, stop);
        chk("store_pc", pc, 32'h4C);

        // PC wrap, illegal opcode, then halt.
        run_instr(6'b100001, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, stop);
        run_instr(6'b001111, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0, stop);
        chk("wrap_pc", pc, 32'h0);
        run_instr(6'b110000, 0, 0, 1'b0, 1'b0, 32'h0, 1'b0, stop);
        chk("illegal_flag", 32'(illegal), 32'h1);
        chk("illegal_pc", pc, 32'h4);
        run_instr(6'b111111, 2, 0, 1'b0, 1'b0, 32'h0, 1'b0, stop);
        hold_terminal();
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc", pc, 32'h4);

        // Fetch ready on the last allowed cycle, then a fetch timeout.
        do_reset();
        begin_run();
        run_instr(6'b000001, int'(TO) - 1, 0, 1'b1, 1'b0, 32'h0, 1'b0, stop);
        chk("late_ready_err", 32'(bus_err), 32'h0);
        run_instr(6'b000001, int'(TO), 0, 1'b1, 1'b0, 32'h0, 1'b0, stop);
        hold_terminal();
        chk("timeout_err", 32'(bus_err), 32'h1);
        chk("timeout_imem_req", 32'(imem_req), 32'h0);

        // Reset while a data access is outstanding.
        do_reset();
        begin_run();
        run_instr(6'b000011, 0, 0, 1'b1, 1'b0, 32'h0, 1'b0, stop);
        run_instr(6'b010001, 0, 2, 1'b1, 1'b0, 32'h0, 1'b1, stop);
        chk("rstmem_dmem_req", 32'(dmem_req), 32'h0);
        chk("rstmem_cnt", instr_cnt, 32'h0);
        chk("rstmem_pc", pc, 32'h0);
        tick();

        // Random instruction streams.
        do_reset();
        begin_run();
        for (int n = 0; n < 300; n++) begin
            int iw, dw;
            iw = ($urandom_range(0, 14) == 0) ? int'(TO) : $urandom_range(0, int'(TO) - 1);
            dw = ($urandom_range(0, 14) == 0) ? int'(TO) : $urandom_range(0, int'(TO) - 1);
            run_instr(rand_op(), iw, dw, 1'($urandom), 1'($urandom),
                      $urandom & 32'hFFFF_FFFC, 1'b0, stop);
            if (stop) begin
                hold_terminal();
                do_reset();
                begin_run();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
